// File: rtl/blink_sched_pkg.sv
// blink_sched_pkg: shared state encoding and width helpers for the blink scheduler.
package blink_sched_pkg;
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
   // Never returns 0, so single-value counters still get a legal vector width.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int id_w(input int num_req);
      return width_of(num_req);
   endfunction
   function automatic int bit_w(input int pattern_width);
      return width_of(pattern_width);
   endfunction
   function automatic int slot_w(input int slot_cycles);
      return width_of(slot_cycles + 1);
   endfunction
endpackage

// File: rtl/blink_sched_if.sv
// blink_sched_if: requester bundle and LED-side status of the blink scheduler.
// BLINK_SCHED_ABORT_EN adds the abort request and the aborted flag.
interface blink_sched_if
   import blink_sched_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int PATTERN_WIDTH = 32
) ();
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ*PATTERN_WIDTH-1:0]   req_pattern;
   logic [NUM_REQ-1:0]                 req_ack;
   logic [id_w(NUM_REQ)-1:0]           active_id;
   logic                               busy;
   logic [bit_w(PATTERN_WIDTH)-1:0]    bit_index;
   logic                               done;
   logic                               LED;
`ifdef BLINK_SCHED_ABORT_EN
   logic                               abort;
   logic                               aborted;
   modport master (output req_valid, req_pattern, abort,
                   input req_ack, active_id, busy, bit_index, done, LED, aborted);
   modport slave (input req_valid, req_pattern, abort,
                  output req_ack, active_id, busy, bit_index, done, LED, aborted);
`else
   modport master (output req_valid, req_pattern,
                   input req_ack, active_id, busy, bit_index, done, LED);
   modport slave (input req_valid, req_pattern,
                  output req_ack, active_id, busy, bit_index, done, LED);
`endif
endinterface

// File: rtl/blink_slot_timer.sv
// blink_slot_timer: free-running slot divider, pulses slot_tick on the last cycle of each slot.
module blink_slot_timer
   import blink_sched_pkg::*;
#(
   parameter int SLOT_CYCLES = 2097152
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic run,
   output logic slot_tick
);
   localparam int W = slot_w(SLOT_CYCLES);
   logic [W-1:0] cnt;
   assign slot_tick = run && cnt == W'(SLOT_CYCLES - 1);
   always_ff @(posedge CLK) begin
      if (RST || clear) cnt <= '0;
      else if (run) cnt <= slot_tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/blink_scheduler.sv
// blink_scheduler: round-robin time-sharing of one LED between pattern requesters.
// Define BLINK_SCHED_ABORT_EN to allow cutting a play short with bus.abort.
module blink_scheduler
   import blink_sched_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int PATTERN_WIDTH = 32,
   parameter int SLOT_CYCLES   = 2097152,
   parameter int REPEATS       = 2,
   parameter int GAP_SLOTS     = 8
) (
   input  logic         CLK,
   input  logic         RST,
   blink_sched_if.slave bus
);
   localparam int ID_W     = id_w(NUM_REQ);
   localparam int BI_W     = bit_w(PATTERN_WIDTH);
   localparam int REP_W    = width_of(REPEATS);
   localparam int GAP_W    = width_of(GAP_SLOTS);
   localparam int GAP_LAST = GAP_SLOTS > 0 ? GAP_SLOTS - 1 : 0;

   state_t                   state, state_nx;
   logic [PATTERN_WIDTH-1:0] pattern_q;
   logic [ID_W-1:0]          last_grant, grant, active_id;
   logic [BI_W-1:0]          bit_index;
   logic [REP_W-1:0]         rep_cnt;
   logic [GAP_W-1:0]         gap_cnt;
   logic [NUM_REQ-1:0]       req_ack;
   logic                     done, aborted, slot_tick, abort_hit, last_bit, play_end, gap_end;

`ifdef BLINK_SCHED_ABORT_EN
   assign abort_hit = bus.abort;
   assign bus.aborted = aborted;
`else
   assign abort_hit = 1'b0;
`endif

   // An abort restarts the slot so the gap that follows is full length.
   blink_slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .clear    (state == IDLE || (state == PLAY && abort_hit)),
      .run      (state != IDLE),
      .slot_tick(slot_tick)
   );

   assign last_bit = bit_index == BI_W'(PATTERN_WIDTH - 1);
   assign play_end = state == PLAY &&
                     (abort_hit || (slot_tick && last_bit && rep_cnt == REP_W'(REPEATS - 1)));
   assign gap_end  = state == GAP && slot_tick && gap_cnt == GAP_W'(GAP_LAST);

   // Nearest requester after last_grant wins; later assignments are closer.
   always_comb begin
      grant = last_grant;
      for (int k = NUM_REQ; k >= 1; k--)
         if (bus.req_valid[(int'(last_grant) + k) % NUM_REQ])
            grant = ID_W'((int'(last_grant) + k) % NUM_REQ);
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = (state == IDLE) ? (|bus.req_valid ? PLAY : IDLE)
               : (state == PLAY) ? (play_end ? (GAP_SLOTS == 0 ? IDLE : GAP) : PLAY)
               : (gap_end ? IDLE : GAP);
   end

   always_comb begin
      bus.LED  = state == PLAY && pattern_q[bit_index];
      bus.busy = state != IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pattern_q  <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
         active_id  <= '0;
         bit_index  <= '0;
         rep_cnt    <= '0;
         gap_cnt    <= '0;
         req_ack    <= '0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         req_ack <= '0;
         done    <= play_end;
         aborted <= play_end && abort_hit;
         if (state == IDLE && |bus.req_valid) begin
            pattern_q  <= bus.req_pattern[grant*PATTERN_WIDTH +: PATTERN_WIDTH];
            active_id  <= grant;
            last_grant <= grant;
            req_ack    <= NUM_REQ'(1) << grant;
            bit_index  <= '0;
            rep_cnt    <= '0;
            gap_cnt    <= '0;
         end else if (state == PLAY && slot_tick && !play_end) begin
            bit_index <= last_bit ? '0 : bit_index + 1'b1;
            if (last_bit) rep_cnt <= rep_cnt + 1'b1;
         end else if (state == GAP && slot_tick && !gap_end) begin
            gap_cnt <= gap_cnt + 1'b1;
         end
      end
   end

   assign bus.req_ack   = req_ack;
   assign bus.active_id = active_id;
   assign bus.bit_index = bit_index;
   assign bus.done      = done;
endmodule
